// File: rtl/y_mat_pkg.sv
// Shared Y-matrix line format: 16 slots of 16 bits packed MSB-first into a 256-bit line.
// Used by both the read-side extractor and the write-side packer.
package y_mat_pkg;

   localparam int SLOTS_PER_LINE = 16;
   localparam int SLOT_W         = 16;
   localparam int ADDR_BITS      = 10;
   localparam int LINE_W         = 256;
   localparam int SLOT_IDX_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE
   } yMatState_t;

   // Slot 0 sits at the top of the line, so slot s spans [255-16s : 240-16s].
   function automatic int slotMsb(input int slot);
      return LINE_W - 1 - SLOT_W * slot;
   endfunction

endpackage

// File: rtl/y_mat_slot_insert.sv
// Combinational slot writer: returns lineIn with one slot replaced by a zero-extended address.
module y_mat_slot_insert
   import y_mat_pkg::*;
(
   input  logic [LINE_W-1:0]     lineIn,
   input  logic [SLOT_IDX_W-1:0] slot,
   input  logic [ADDR_BITS-1:0]  addr,
   output logic [LINE_W-1:0]     lineOut
);

   always_comb begin
      // NOTE: assigning a full default first keeps this block free of inferred latches.
      lineOut = lineIn;
      lineOut[slotMsb(int'(slot)) -: SLOT_W] = {{(SLOT_W - ADDR_BITS){1'b0}}, addr};
   end

endmodule

// File: rtl/put_y_mat_address.sv
// Packs (row, row-address) entries into 256-bit Y-matrix lines and writes each full or
// flushed line to the Y-matrix memory over a valid/ack handshake.
module put_y_mat_address
   import y_mat_pkg::*;
#(
   parameter int LINE_ADDR_W = 12
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   pYMA_valid,
   output logic                   pYMA_ready,
   input  logic [15:0]            pYMA_row,
   input  logic [10:0]            pYMA_addr,
   input  logic                   pYMA_flush,
   output logic                   pYMA_wrEnable,
   output logic [LINE_ADDR_W-1:0] pYMA_wrAddr,
   output logic [LINE_W-1:0]      pYMA_wrData,
   input  logic                   pYMA_wrAck,
   output logic                   pYMA_addrErr,
   output logic                   pYMA_busy
);

   yMatState_t                state, stateNext;
   logic [LINE_W-1:0]         lineBuf, lineBufNext;
   logic [LINE_ADDR_W-1:0]    lineIdx, lineIdxNext;
   logic [SLOTS_PER_LINE-1:0] slotMask, slotMaskNext;
   logic                      pendValid, pendValidNext;
   logic [LINE_ADDR_W-1:0]    pendLine, pendLineNext;
   logic [SLOT_IDX_W-1:0]     pendSlot, pendSlotNext;
   logic [ADDR_BITS-1:0]      pendAddr, pendAddrNext;
   logic                      flushPend, flushPendNext;
   logic                      readyReg, readyNext;
   logic                      addrErrReg, addrErrNext;

   logic                      accept;
   logic [LINE_ADDR_W-1:0]    inLine;
   logic [SLOTS_PER_LINE-1:0] inBit, pendBit;
   logic [LINE_W-1:0]         lineWithEntry, lineFromPend;

   assign accept  = pYMA_valid && readyReg;
   assign inLine  = pYMA_row[LINE_ADDR_W+3:4];
   assign inBit   = SLOTS_PER_LINE'(1) << pYMA_row[SLOT_IDX_W-1:0];
   assign pendBit = SLOTS_PER_LINE'(1) << pendSlot;

   y_mat_slot_insert u_insertEntry (
      .lineIn  (lineBuf),
      .slot    (pYMA_row[SLOT_IDX_W-1:0]),
      .addr    (pYMA_addr[ADDR_BITS-1:0]),
      .lineOut (lineWithEntry)
   );

   // A held entry always starts a fresh line, so it is inserted into an empty one.
   y_mat_slot_insert u_insertPend (
      .lineIn  ('0),
      .slot    (pendSlot),
      .addr    (pendAddr),
      .lineOut (lineFromPend)
   );

   always_ff @(posedge clock) begin
      // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
      if (reset) begin
         state      <= IDLE;
         // NOTE: the line buffer is reset because wrData must read zero and unwritten slots stay zero.
         lineBuf    <= '0;
         lineIdx    <= '0;
         slotMask   <= '0;
         pendValid  <= 1'b0;
         pendLine   <= '0;
         pendSlot   <= '0;
         pendAddr   <= '0;
         flushPend  <= 1'b0;
         readyReg   <= 1'b0;
         addrErrReg <= 1'b0;
      end else begin
         state      <= stateNext;
         lineBuf    <= lineBufNext;
         lineIdx    <= lineIdxNext;
         slotMask   <= slotMaskNext;
         pendValid  <= pendValidNext;
         pendLine   <= pendLineNext;
         pendSlot   <= pendSlotNext;
         pendAddr   <= pendAddrNext;
         flushPend  <= flushPendNext;
         readyReg   <= readyNext;
         addrErrReg <= addrErrNext;
      end
   end

   always_comb begin
      stateNext     = state;
      lineBufNext   = lineBuf;
      lineIdxNext   = lineIdx;
      slotMaskNext  = slotMask;
      pendValidNext = pendValid;
      pendLineNext  = pendLine;
      pendSlotNext  = pendSlot;
      pendAddrNext  = pendAddr;
      flushPendNext = flushPend;
      addrErrNext   = accept && pYMA_addr[ADDR_BITS];

      case (state)
         IDLE, FILL: begin
            if (accept) begin
               if (state == IDLE || inLine == lineIdx) begin
                  lineBufNext  = lineWithEntry;
                  lineIdxNext  = inLine;
                  slotMaskNext = slotMask | inBit;
                  if (slotMaskNext == '1 || pYMA_flush)
                     stateNext = WRITE;
                  else
                     stateNext = FILL;
               end else begin
                  // Entry for another line waits while the current line is written out.
                  pendValidNext = 1'b1;
                  pendLineNext  = inLine;
                  pendSlotNext  = pYMA_row[SLOT_IDX_W-1:0];
                  pendAddrNext  = pYMA_addr[ADDR_BITS-1:0];
                  flushPendNext = pYMA_flush;
                  stateNext     = WRITE;
               end
            end else if (pYMA_flush && slotMask != '0) begin
               stateNext = WRITE;
            end
         end
         WRITE: begin
            if (pYMA_flush)
               flushPendNext = 1'b1;
            if (pYMA_wrAck) begin
               lineBufNext   = '0;
               slotMaskNext  = '0;
               flushPendNext = 1'b0;
               if (pendValid) begin
                  lineBufNext   = lineFromPend;
                  lineIdxNext   = pendLine;
                  slotMaskNext  = pendBit;
                  pendValidNext = 1'b0;
                  stateNext     = (flushPend || pYMA_flush) ? WRITE : FILL;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: stateNext = IDLE;
      endcase

      readyNext = (stateNext != WRITE) && !pendValidNext;
   end

   always_comb begin
      pYMA_ready    = readyReg;
      pYMA_addrErr  = addrErrReg;
      pYMA_wrEnable = (state == WRITE);
      pYMA_wrAddr   = (state == WRITE) ? lineIdx : '0;
      pYMA_wrData   = (state == WRITE) ? lineBuf : '0;
      pYMA_busy     = (slotMask != '0) || pendValid || (state == WRITE);
   end

endmodule

// File: doc/put_y_mat_address.md
Name: put_y_mat_address

Overview:
- Write-side counterpart of the Y-matrix address extractor. Accepts a stream of (row, row-address) entries and packs 16 entries into one 256-bit Y-matrix line, using the line format the read-side extractor decodes.
- Issues each completed or flushed line to the Y-matrix memory over a valid/ack write handshake.
- Sits between the Y-matrix build controller and the Y-matrix memory write port.

Parameters:
LINE_ADDR_W, 12, width of memory line address; line index = row[LINE_ADDR_W+3:4]
SLOT_W, 16, bits per slot in a 256-bit line (fixed; 16 slots per line)
ADDR_BITS, 10, stored address bits per slot; slot bits above ADDR_BITS are written as 0

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
pYMA_valid  in  1  entry offered this cycle
pYMA_ready  out  1  registered; entry accepted on valid && ready
pYMA_row  in  16  row number; slot = row[3:0], line = row[LINE_ADDR_W+3:4]
pYMA_addr  in  11  row address to store
pYMA_flush  in  1  one-cycle request: write partial line
pYMA_wrEnable  out  1  write request to Y-matrix memory
pYMA_wrAddr  out  LINE_ADDR_W  line address of write
pYMA_wrData  out  256  packed line
pYMA_wrAck  in  1  memory accepted write (sampled while wrEnable high)
pYMA_addrErr  out  1  one-cycle pulse: accepted entry had addr[10]=1 (bit dropped)
pYMA_busy  out  1  high when buffer non-empty, pending held, or in WRITE

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Slot layout: slot s occupies wrData[255-16s : 240-16s]. addr[9:0] goes to [249-16s : 240-16s]; bits [255-16s : 250-16s] = 0. Unwritten slots = 0.
- State: line buffer (256b), current line index, 16-bit slot mask, one-entry pending register, flush-pending flag.
- FSM states: IDLE (mask=0), FILL (mask!=0), WRITE (wrEnable high, awaiting ack).
- Reset: state=IDLE. wrEnable=0, wrAddr=0, wrData=0, ready=0, addrErr=0, busy=0. Mask, pending and flush-pending cleared. ready rises the first cycle after reset deasserts.
- Accept, IDLE: latch line index, write slot, set mask bit. Go to FILL. If the mask is now 16'hFFFF (impossible on first entry), handle as in FILL.
- Accept, FILL, same line: write slot. A duplicate slot is overwritten; mask unchanged. If mask becomes 16'hFFFF, go to WRITE on the next edge.
- Accept, FILL, different line: store the entry in pending, go to WRITE. Current line is written first.
- ready = 1 only in IDLE/FILL with pending empty and not transitioning to WRITE. Registered: it drops the cycle after the accept that causes WRITE.
- WRITE: wrEnable=1, wrAddr/wrData stable until the edge where wrAck=1.
  - On that edge: clear buffer and mask.
  - If pending is valid, load it as the first entry of a new buffer, enter FILL, clear pending.
  - Else enter IDLE.
  - ready=1 the following cycle.
- Write latency: a line completed by the accept at edge T has wrEnable high from cycle T+1. Minimum one cycle in WRITE when wrAck is held high.
- Flush, IDLE or mask=0: ignored, no write.
- Flush, FILL: go to WRITE.
- Flush with a same-cycle accepted entry: the entry is included first.
  - Same line: one write.
  - Mismatched line: current line is written; pending is merged; flush-pending is set; the merged line is then written immediately (two writes total).
- Flush in WRITE: set flush-pending, applied after the ack per the rules above.
- Full line plus flush in the same cycle: exactly one write.
- addrErr: pulses in the cycle after an accepted entry with addr[10]=1. The entry is still stored (addr[9:0]).
- Reset mid-WRITE: wrEnable=0 the next cycle. Buffered, pending and flush data are discarded.

Decomposition:
- Shared package (y_mat_pkg): SLOTS_PER_LINE=16, SLOT_W=16, ADDR_BITS=10, LINE_W=256, and a slot-offset function (255-16s) used by both the extractor and this packer.
- Sub-module y_mat_slot_insert (combinational): line, slot, addr in → updated line out.
- FSM and handshake stay in the top module.

Test Plan:
- Rows 0..15 (line 0), addr = 11'h100+row, back-to-back → one write:
  - wrAddr=0.
  - wrData[249:240]=10'h100, wrData[9:0]=10'h10F.
  - Upper 6 bits of every slot = 0.
  - wrEnable rises the cycle after the 16th accept.
- Rows 0x20, 0x21, then flush → write wrAddr=2, slot0=addr0, slot1=addr1, slots 2..15 = 0. Flush with an empty buffer → no wrEnable.
- Row 0x05 then row 0x13 → line 0 written with only slot5. ready low during WRITE. After ack, line 1 is held with slot3. Flush → second write wrAddr=1.
- Duplicate row 0x07 with addr 10, then 20; then flush → slot7 = 20.
- wrAck held low 10 cycles → wrEnable/wrAddr/wrData stable and ready=0 throughout. Ack → ready=1 next cycle.
- Entry with addr=11'h7FF → stored 10'h3FF, addrErr pulses once. Reset asserted mid-WRITE → wrEnable=0, busy=0 next cycle, no further write.
